mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external RAM port between two requesters: instruction fetch (IF) and the MEM-stage data access.
- The MEM-stage requester consumes ramAddr/ramSel/loadop/result from the memory-access ALU.
- Sequences multi-cycle RAM transactions using a ce/ack handshake.
- Formats load data per loadop and raises a pipeline stall request while any transaction is outstanding.

Parameters:
- ADDR_W, 32, RAM address width.
- DATA_W, 32, data width. Fixed at 32; byte-lane logic assumes 4 lanes.

Ports:
- clk  in  1  system clock. Single clock domain; everything is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch address; word-aligned.
- if_rdata  out  32  fetched instruction; valid when if_done=1.
- if_done  out  1  one-cycle completion pulse for the fetch.
- mem_sel  in  4  store byte-enable; nonzero means a store.
- mem_loadop  in  3  load op; nonzero means a load.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  32  lane-replicated store data.
- mem_rdata  out  32  formatted load result; valid when mem_done=1.
- mem_done  out  1  one-cycle completion pulse for a data access.
- stall_req  out  1  pipeline stall request.
- ram_ce  out  1  RAM transaction active.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_sel  out  4  RAM byte enables.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; valid when ram_ack=1.
- ram_ack  in  1  RAM completion; arrives 1..N cycles after ce rises.

Behaviour:
- Data-request condition: mem_req = (mem_sel != 0) | (mem_loadop != LOADOP_NOP).
- Reset:
  - State goes to IDLE.
  - ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, if_rdata, mem_rdata, if_done, mem_done are all 0.
- FSM states: IDLE, IF_BUSY, MEM_BUSY, DONE.
- IDLE:
  - mem_req → latch addr/sel/wdata/loadop, go to MEM_BUSY.
  - else if_req → latch if_addr, go to IF_BUSY.
  - Fixed priority: MEM over IF.
- BUSY states:
  - Registered outputs are driven from latched values: ram_ce=1; ram_we=1 only for a store.
  - IF fetch drives ram_sel=4'b1111.
  - Data access drives ram_sel = latched sel for a store, 4'b1111 for a load.
  - Requester inputs are ignored while busy.
- Completion:
  - When ram_ack=1 in a BUSY state, go to DONE next cycle.
  - In DONE: ram_ce=0 and ram_we=0; the matching done output is 1 for exactly that one cycle.
  - if_rdata captures ram_rdata; mem_rdata captures the formatted load value, or 0 for a store.
  - DONE → IDLE unconditionally. A pending other request is granted from IDLE on the following cycle.
- Latency: request seen in IDLE at cycle N → ram_ce=1 from N+1. ack at cycle M → done at M+1.
- ram_ack outside a BUSY state is ignored.
- Load formatting (little-endian lanes, a = latched addr[1:0]):
  - LB: sign-extend byte[a].
  - LBU: zero-extend byte[a].
  - LH: sign-extend half[a[1]].
  - LHU: zero-extend half[a[1]].
  - LW: full word.
  - Misalignment is not checked: a[0] is ignored for halfwords; a is ignored for words.
- stall_req = (if_req & ~if_done) | (mem_req & ~mem_done), combinational. It is asserted the same cycle a request appears and drops in the done cycle.
- Reset mid-transaction: return to IDLE next edge and drop ram_ce. A pending ack is ignored and no done pulse is issued.
- Requester contract: a requester must hold its request stable until its done. Behaviour on an early drop: the latched transaction still completes and done still pulses.

Decomposition:
- Shared package holds:
  - LOADOP codes: NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5.
  - FSM state encoding.
  - ZERO_WORD.
- One sub-module, load_formatter: combinational; inputs loadop, addr[1:0], word; output formatted word. Reused by any later cache fill path.

Test Plan:
- IF only: if_req=1, if_addr=0x100, ack 2 cycles after ce.
  - → ram_ce high for 3 cycles with ram_sel=1111, ram_we=0.
  - → if_done pulse 1 cycle with if_rdata=ram_rdata=0x8C010004.
- Concurrent requests: if_req and LW mem_addr=0x200 asserted in the same cycle.
  - → MEM is served first (ram_addr=0x200), then IF (ram_addr=0x100).
  - → stall_req stays high until if_done.
- Store: SB, mem_addr=0x203, mem_sel=1000, wdata=0x5A5A5A5A.
  - → ram_we=1, ram_sel=1000, ram_wdata=0x5A5A5A5A.
  - → mem_done with mem_rdata=0.
- Load formatting, ram_rdata=0x80FF7F01:
  - → LB@0x1 gives 0x0000007F.
  - → LB@0x3 gives 0xFFFFFF80.
  - → LBU@0x2 gives 0x000000FF.
  - → LH@0x2 gives 0xFFFF80FF.
  - → LHU@0x0 gives 0x00007F01.
- Reset mid-operation: rst=1 during MEM_BUSY, followed by ack.
  - → next cycle ram_ce=0, state IDLE.
  - → no mem_done pulse.
- Zero-latency ack: ram_ack=1 in the first ce cycle.
  - → done next cycle; ce is high exactly 1 cycle.
  - → a stray ack while IDLE changes nothing.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared load-op codes, arbiter state encoding and constants
package mem_port_arbiter_pkg;
  typedef logic [2:0] loadop_t;
  localparam loadop_t LOADOP_NOP = 3'd0;
  localparam loadop_t LOADOP_LB  = 3'd1;
  localparam loadop_t LOADOP_LBU = 3'd2;
  localparam loadop_t LOADOP_LH  = 3'd3;
  localparam loadop_t LOADOP_LHU = 3'd4;
  localparam loadop_t LOADOP_LW  = 3'd5;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_IF_BUSY  = 2'd1;
  localparam logic [1:0] ST_MEM_BUSY = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;
  localparam logic [31:0] ZERO_WORD = 32'h0;
endpackage

// File: rtl/mem_port_arbiter_load_formatter.sv
// load_formatter: extracts and sign/zero-extends a little-endian byte/half/word (loadop, addr[1:0], word -> data)
module load_formatter
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  loadop,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    data = loadop == LOADOP_LB  ? {{24{b[7]}}, b} :
           loadop == LOADOP_LBU ? {24'h0, b} :
           loadop == LOADOP_LH  ? {{16{h[15]}}, h} :
           loadop == LOADOP_LHU ? {16'h0, h} :
           loadop == LOADOP_LW  ? word : ZERO_WORD;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port (ram_*) between fetch (if_*) and MEM-stage data (mem_*) requesters, MEM first, with stall_req
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic [3:0]        mem_sel,
  input  logic [2:0]        mem_loadop,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_req,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);
  logic [1:0]  state;
  logic [2:0]  lat_loadop;
  logic        lat_store;
  logic        mem_req;
  logic [31:0] fmt;
  assign mem_req   = (mem_sel != 4'b0000) | (mem_loadop != LOADOP_NOP);
  assign stall_req = (if_req & ~if_done) | (mem_req & ~mem_done);
  load_formatter u_fmt (
    .loadop(lat_loadop),
    .addr  (ram_addr[1:0]),
    .word  (ram_rdata),
    .data  (fmt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_sel    <= 4'b0000;
      ram_wdata  <= ZERO_WORD;
      if_rdata   <= ZERO_WORD;
      mem_rdata  <= ZERO_WORD;
      if_done    <= 1'b0;
      mem_done   <= 1'b0;
      lat_loadop <= LOADOP_NOP;
      lat_store  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      if (state == ST_IDLE) begin
        if (mem_req) begin
          state      <= ST_MEM_BUSY;
          ram_ce     <= 1'b1;
          ram_we     <= mem_sel != 4'b0000;
          ram_addr   <= mem_addr;
          ram_sel    <= mem_sel != 4'b0000 ? mem_sel : 4'b1111;
          ram_wdata  <= mem_sel != 4'b0000 ? mem_wdata : ZERO_WORD;
          lat_loadop <= mem_loadop;
          lat_store  <= mem_sel != 4'b0000;
        end else if (if_req) begin
          state     <= ST_IF_BUSY;
          ram_ce    <= 1'b1;
          ram_we    <= 1'b0;
          ram_addr  <= if_addr;
          ram_sel   <= 4'b1111;
          ram_wdata <= ZERO_WORD;
        end
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end else if (ram_ack) begin
        state  <= ST_DONE;
        ram_ce <= 1'b0;
        ram_we <= 1'b0;
        if (state == ST_IF_BUSY) begin
          if_rdata <= ram_rdata;
          if_done  <= 1'b1;
        end else begin
          mem_rdata <= lat_store ? ZERO_WORD : fmt;
          mem_done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic [3:0]  mem_sel;
  logic [2:0]  mem_loadop;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stall_req;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_sel(mem_sel), .mem_loadop(mem_loadop), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_req(stall_req),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fmt(input int op, input logic [31:0] a, input logic [31:0] w);
    int unsigned b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
    int unsigned h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (op)
      1: return b >= 128 ? b + 32'hFFFFFF00 : b;
      2: return b;
      3: return h >= 32768 ? h + 32'hFFFF0000 : h;
      4: return h;
      5: return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit tb_mem_req();
    return (mem_sel != 4'b0) || (mem_loadop != 3'd0);
  endfunction

  // Called at the negedge on which the request was driven; plays the RAM with the given ack latency.
  task automatic serve(input bit is_mem, input logic [31:0] ea, input bit ewe, input logic [3:0] esel,
                       input logic [31:0] ewd, input int lat, input logic [31:0] rd, input logic [31:0] exp_rd);
    @(negedge clk);
    for (int k = 0; k <= lat; k++) begin
      chk("ram_ce_busy", ram_ce, 1);
      chk("ram_addr", ram_addr, ea);
      chk("ram_we", ram_we, ewe);
      chk("ram_sel", ram_sel, esel);
      if (ewe) chk("ram_wdata", ram_wdata, ewd);
      chk("stall_busy", stall_req, 1);
      if (k == lat) begin
        ram_ack = 1'b1;
        ram_rdata = rd;
      end
      @(negedge clk);
      ram_ack = 1'b0;
      ram_rdata = $urandom;
    end
    chk("ram_ce_done", ram_ce, 0);
    chk("ram_we_done", ram_we, 0);
    chk("if_done", if_done, !is_mem);
    chk("mem_done", mem_done, is_mem);
    if (is_mem) chk("mem_rdata", mem_rdata, exp_rd);
    else chk("if_rdata", if_rdata, exp_rd);
    chk("stall_done", stall_req, is_mem ? if_req : tb_mem_req());
    if (is_mem) begin
      mem_sel = 4'b0;
      mem_loadop = 3'd0;
    end else if_req = 1'b0;
    @(negedge clk);
    chk("if_done_pulse", if_done, 0);
    chk("mem_done_pulse", mem_done, 0);
  endtask

  int ops[5] = '{1, 1, 2, 3, 4};
  logic [31:0] adrs[5] = '{32'h1, 32'h3, 32'h2, 32'h2, 32'h0};
  logic [31:0] exps[5] = '{32'h0000007F, 32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01};

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; mem_sel = 0; mem_loadop = 0; mem_addr = 0; mem_wdata = 0;
    ram_rdata = 0; ram_ack = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ce", ram_ce, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_sel", ram_sel, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_mem_done", mem_done, 0);
    chk("rst_stall", stall_req, 0);

    // fetch only, ack two cycles after ce
    if_req = 1; if_addr = 32'h100;
    #1 chk("stall_same_cycle", stall_req, 1);
    serve(0, 32'h100, 0, 4'hF, 0, 2, 32'h8C010004, 32'h8C010004);

    // concurrent: MEM granted before IF
    if_req = 1; if_addr = 32'h100; mem_loadop = 3'd5; mem_addr = 32'h200;
    serve(1, 32'h200, 0, 4'hF, 0, 1, 32'h12345678, 32'h12345678);
    serve(0, 32'h100, 0, 4'hF, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D);

    // byte store
    mem_sel = 4'b1000; mem_addr = 32'h203; mem_wdata = 32'h5A5A5A5A;
    serve(1, 32'h203, 1, 4'b1000, 32'h5A5A5A5A, 1, 32'hFFFFFFFF, 32'h0);

    // load formatting
    for (int i = 0; i < 5; i++) begin
      mem_loadop = 3'(ops[i]); mem_addr = adrs[i];
      serve(1, adrs[i], 0, 4'hF, 0, 1, 32'h80FF7F01, exps[i]);
    end

    // reset while MEM busy, with an ack in the same cycle
    mem_loadop = 3'd5; mem_addr = 32'h300;
    @(negedge clk);
    chk("rst_mid_ce_before", ram_ce, 1);
    ram_ack = 1; ram_rdata = 32'hDEADBEEF; rst = 1;
    @(negedge clk);
    ram_ack = 0; rst = 0; mem_loadop = 3'd0;
    chk("rst_mid_ce", ram_ce, 0);
    chk("rst_mid_done", mem_done, 0);
    @(negedge clk);
    chk("rst_mid_done2", mem_done, 0);
    chk("rst_mid_ce2", ram_ce, 0);

    // stray ack while idle
    ram_ack = 1;
    @(negedge clk);
    ram_ack = 0;
    @(negedge clk);
    chk("stray_ce", ram_ce, 0);
    chk("stray_if_done", if_done, 0);
    chk("stray_mem_done", mem_done, 0);

    // zero-latency ack
    if_req = 1; if_addr = 32'h400;
    serve(0, 32'h400, 0, 4'hF, 0, 0, 32'h0BADF00D, 32'h0BADF00D);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      bit do_if, do_mem, st;
      int op, sz, lm, li;
      logic [31:0] ma, ia, wd, rdm, rdi;
      logic [3:0] sel;
      do_mem = $urandom_range(0, 1) == 1;
      do_if = !do_mem || ($urandom_range(0, 2) == 0);
      st = $urandom_range(0, 2) == 0;
      op = $urandom_range(1, 5);
      sz = $urandom_range(0, 2);
      ma = $urandom; ia = {$urandom} & 32'hFFFFFFFC; wd = $urandom; rdm = $urandom; rdi = $urandom;
      lm = $urandom_range(0, 3); li = $urandom_range(0, 3);
      sel = sz == 0 ? 4'(1 << ma[1:0]) : sz == 1 ? (ma[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      if (do_if) begin if_req = 1; if_addr = ia; end
      if (do_mem) begin
        mem_addr = ma; mem_wdata = wd;
        if (st) mem_sel = sel; else mem_loadop = 3'(op);
      end
      if (do_mem) serve(1, ma, st, st ? sel : 4'hF, wd, lm, rdm, st ? 32'h0 : ref_fmt(op, ma, rdm));
      if (do_if) serve(0, ia, 0, 4'hF, 0, li, rdi, rdi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
